rgb2ycbcr_ctrl: RTL

//  Stream controller for the fixed-latency rgb2ycbcr pipeline. That pipeline cannot stall.
//  - Input: valid/ready pixels, each with SOF/EOL sideband.
//  - Drives the converter, tags in-flight pixels and catches its results in an output FIFO.
//  - Output: valid/ready, so downstream backpressure never loses a converted pixel.

---
 rtl/rgb2ycbcr_ctrl_if.sv | 52 +++++
 rtl/rgb2ycbcr_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_ctrl_if.sv
// Stream bundle for the rgb2ycbcr controller.
// Groups the pixel input handshake, the converter drive/return path,
// the pixel output handshake and the status signals.
//   slave  : controller view (module port of rgb2ycbcr_ctrl)
//   master : environment view (pixel source, converter, pixel sink)
interface rgb2ycbcr_ctrl_if #(
    parameter int CNT_W = 16
);
    // pixel input
    logic             iValid;
    logic             oReady;
    logic [7:0]       iR;
    logic [7:0]       iG;
    logic [7:0]       iB;
    logic             iSof;
    logic             iEol;
    logic             iFlush;
    // converter drive and results
    logic             oConvCe;
    logic [7:0]       oConvR;
    logic [7:0]       oConvG;
    logic [7:0]       oConvB;
    logic [7:0]       iConvY;
    logic [7:0]       iConvCb;
    logic [7:0]       iConvCr;
    // pixel output
    logic             oValid;
    logic             iReady;
    logic [7:0]       oY;
    logic [7:0]       oCb;
    logic [7:0]       oCr;
    logic             oSof;
    logic             oEol;
    logic [CNT_W-1:0] oPixCnt;
    logic             oBusy;

    modport slave (
        input  iValid, iR, iG, iB, iSof, iEol, iFlush,
        input  iConvY, iConvCb, iConvCr,
        input  iReady,
        output oReady, oConvCe, oConvR, oConvG, oConvB,
        output oValid, oY, oCb, oCr, oSof, oEol, oPixCnt, oBusy
    );

    modport master (
        output iValid, iR, iG, iB, iSof, iEol, iFlush,
        output iConvY, iConvCb, iConvCr,
        output iReady,
        input  oReady, oConvCe, oConvR, oConvG, oConvB,
        input  oValid, oY, oCb, oCr, oSof, oEol, oPixCnt, oBusy
    );
endinterface

// File: rtl/rgb2ycbcr_ctrl.sv
// Stream controller wrapped around a fixed-latency, non-stallable
// RGB->YCbCr converter.
//   iClk   : clock
//   iRst   : asynchronous reset, active-low
//   bus    : rgb2ycbcr_ctrl_if.slave
//            pixel in   iValid/oReady, iR/iG/iB, iSof/iEol, iFlush (drain request)
//            converter  oConvCe, oConvR/G/B (registered) -> iConvY/Cb/Cr
//            pixel out  oValid/iReady, oY/oCb/oCr, oSof/oEol (FIFO head, FWFT)
//            status     oPixCnt (pixels out since last SOF), oBusy
// Pixels are only accepted while a FIFO slot is reserved for them
// (in flight + queued < FIFO_DEPTH), so converter results can always be
// caught even under full downstream backpressure.
module rgb2ycbcr_ctrl #(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic            iClk,
    input  logic            iRst,
    rgb2ycbcr_ctrl_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int UW = $clog2(FIFO_DEPTH + 1);
    localparam logic [UW-1:0]    DEPTH_U = UW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t           state;
    logic             alive;
    logic [UW-1:0]    used;
    logic [UW-1:0]    used_nxt;
    logic             ready;
    logic             accept;
    logic             pop;

    logic             conv_ce_p0;
    logic [7:0]       conv_r_p0;
    logic [7:0]       conv_g_p0;
    logic [7:0]       conv_b_p0;
    logic             sof_p0;
    logic             eol_p0;

    logic [LATENCY:0] vld_p1;
    logic [LATENCY:0] sof_p1;
    logic [LATENCY:0] eol_p1;

    logic [25:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [UW-1:0]    fifo_cnt;
    logic             fifo_wr;
    logic             vld_out;
    logic [25:0]      head;
    logic [CNT_W-1:0] pix_cnt;

    // alive keeps oReady low while reset is asserted and for the first edge after it
    assign ready   = alive && (used < DEPTH_U) && (state != FLUSH) && !bus.iFlush;
    assign accept  = bus.iValid && ready;
    assign vld_out = (fifo_cnt != '0);
    assign pop     = vld_out && bus.iReady;
    assign fifo_wr = vld_p1[LATENCY];
    assign head    = mem[rd_ptr];

    always_comb begin
        used_nxt = used;
        case ({accept, pop})
            2'b10:   used_nxt = used + UW'(1);
            2'b01:   used_nxt = used - UW'(1);
            default: used_nxt = used;
        endcase
    end

    // ---- stage p0: converter input registers, held between accepts ----
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            conv_ce_p0 <= 1'b0;
            conv_r_p0  <= '0;
            conv_g_p0  <= '0;
            conv_b_p0  <= '0;
            sof_p0     <= 1'b0;
            eol_p0     <= 1'b0;
        end else begin
            conv_ce_p0 <= accept;
            if (accept) begin
                conv_r_p0 <= bus.iR;
                conv_g_p0 <= bus.iG;
                conv_b_p0 <= bus.iB;
                sof_p0    <= bus.iSof;
                eol_p0    <= bus.iEol;
            end
        end
    end

    // ---- stage p1: tags ride alongside the converter pipe ----
    // Bit 0 lines up with the converter's input registers, bit LATENCY with
    // its valid outputs; the tag emerging there writes the FIFO next edge.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            vld_p1 <= '0;
            sof_p1 <= '0;
            eol_p1 <= '0;
        end else begin
            vld_p1 <= {vld_p1[LATENCY-1:0], conv_ce_p0};
            sof_p1 <= {sof_p1[LATENCY-1:0], sof_p0};
            eol_p1 <= {eol_p1[LATENCY-1:0], eol_p0};
        end
    end

    // ---- stage p2: output FIFO ----
    always_ff @(posedge iClk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= {bus.iConvY, bus.iConvCb, bus.iConvCr, sof_p1[LATENCY], eol_p1[LATENCY]};
        end
    end

    // Credit accounting guarantees a free slot for every write, so no full check.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            pix_cnt  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (head[1]) begin
                    pix_cnt <= CNT_W'(1);
                end else if (pix_cnt != CNT_MAX) begin
                    pix_cnt <= pix_cnt + CNT_W'(1);
                end
            end
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt <= fifo_cnt + UW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - UW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---- control: credit counter and stream state ----
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
            used  <= '0;
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
            used  <= used_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.iFlush) begin
                        state <= FLUSH;
                    end else if (used_nxt == '0 && !accept) begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (used_nxt == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oReady  = ready;
    assign bus.oConvCe = conv_ce_p0;
    assign bus.oConvR  = conv_r_p0;
    assign bus.oConvG  = conv_g_p0;
    assign bus.oConvB  = conv_b_p0;
    // head data is masked while empty so an idle or reset FIFO presents zeros
    assign bus.oValid  = vld_out;
    assign bus.oY      = vld_out ? head[25:18] : 8'd0;
    assign bus.oCb     = vld_out ? head[17:10] : 8'd0;
    assign bus.oCr     = vld_out ? head[9:2]   : 8'd0;
    assign bus.oSof    = vld_out & head[1];
    assign bus.oEol    = vld_out & head[0];
    assign bus.oPixCnt = pix_cnt;
    assign bus.oBusy   = (used != '0) || (state != IDLE);
endmodule
